move_list_writer: RTL and testbench
===================================

Name: move_list_writer

Overview:
- Avalon-MM write master that sits directly upstream of the SDRAM controller slave inside the system (16-bit SDRAM data path).
- Accepts the move generator's stream of 16-bit encoded moves through a small FIFO and writes them as a contiguous list into SDRAM.
- Writes a count header last and signals completion so the search logic can read the list back.

Parameters:
- FIFO_DEPTH, 16, move FIFO entries; power of 2, minimum 4.
- ADDR_W, 32, Avalon byte-address width.
- MAX_MOVES, 255, list capacity; moves beyond this are dropped.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a list. Ignored unless IDLE.
- base_addr  in  ADDR_W  list byte address; sampled on start; must be 2-byte aligned.
- mv_valid  in  1  move stream valid.
- mv_data  in  16  move: [5:0] from, [11:6] to, [13:12] promo, [15:14] flags.
- mv_last  in  1  qualifies the final beat. mv_last with mv_valid=0 on its own (empty list) is legal while in FILL.
- mv_ready  out  1  move stream ready.
- avm_address  out  ADDR_W  write byte address.
- avm_write  out  1  write request.
- avm_writedata  out  16  write data.
- avm_byteenable  out  2  always 2'b11.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the header write is accepted.
- move_count  out  8  moves stored in the current or last list.
- overflow  out  1  sticky; set when a move is dropped; cleared on start.
- checksum  out  16  see Optional Feature.

Behaviour:
- Reset values: every output is 0 except avm_byteenable=2'b11. FSM = IDLE, FIFO empty.
- FSM states:
  - IDLE -> FILL on start. Clears move_count, overflow and checksum, and latches base_addr.
  - FILL: mv_ready = !fifo_full. A beat is accepted on any edge with mv_valid && mv_ready.
    - Accepted moves with index < MAX_MOVES are pushed to the FIFO.
    - Later moves are accepted and discarded, and overflow is set.
    - Accepting mv_last, or seeing mv_last with !mv_valid, moves to DRAIN.
  - DRAIN: mv_ready=0. Go to HEADER when the FIFO is empty and no write is outstanding.
  - HEADER: write {8'h00, move_count} to base_addr. When it is accepted, pulse done and go to IDLE.
- Move address: move i (0-based) is written to base_addr + 2*(i+1); base_addr itself holds the header.
- Avalon rules:
  - avm_address, avm_write and avm_writedata are held stable while avm_waitrequest=1.
  - A write is accepted on an edge with avm_write && !avm_waitrequest.
  - After an acceptance, the next FIFO word may be presented on the following cycle; back-to-back writes are allowed.
- move_count increments on each FIFO push, not on bus acceptance. It saturates at MAX_MOVES.
- Latency with an idle bus: a move accepted on edge k has avm_write=1 with that data after edge k+2.
- FIFO full: mv_ready drops the same cycle (combinational from FIFO count). Push and pop in the same cycle are allowed when full.
- Empty list: header 0x0000 is written to base_addr and done pulses; no move writes occur.
- start while busy: ignored with no side effect.
- Reset mid-operation: avm_write drops asynchronously. The FIFO is flushed, the partial list is abandoned and done is not pulsed.

Optional Feature:
- Macro: MOVE_WR_CHECKSUM_EN.
- Defined: checksum = running XOR of every move pushed to the FIFO (dropped moves excluded). It is cleared on start and stable after done.
- Undefined: checksum is tied to 16'h0000 and no XOR logic is generated.

Decomposition:
- Package chess_mem_pkg holds:
  - move_t packed struct (from, to, promo, flags).
  - Constant HDR_OFFSET = 0 and constant MOVE_STRIDE = 2.
  - FSM state enum {IDLE, FILL, DRAIN, HEADER}.
- Sub-module move_fifo: synchronous FIFO with parameter FIFO_DEPTH, width 16, full/empty/count outputs, and same-cycle push/pop support.

Test Plan:
- base_addr=0x1000, 3 moves 0x0A1C,0x1234,0xC0FF with last on the third, waitrequest=0 -> writes 0x1002=0x0A1C, 0x1004=0x1234, 0x1006=0xC0FF, then 0x1000=0x0003; one done pulse; move_count=3.
- waitrequest held high for 5 cycles on the second move write -> address and data stable throughout; mv_ready falls once FIFO_DEPTH entries are queued; list contents unchanged.
- start, then mv_last with mv_valid=0 -> single write 0x0000 to base_addr; done pulses; move_count=0.
- 257 moves with MAX_MOVES=255 -> 255 move writes, header 0x00FF, overflow=1, all 257 beats accepted.
- reset asserted while in DRAIN with an outstanding write -> avm_write=0 immediately, busy=0, no done; a new start writes a correct list.
- With MOVE_WR_CHECKSUM_EN and moves 0x0F0F,0x00FF -> checksum=0x0FF0 after done.

Source files
------------

// File: rtl/chess_mem_pkg.sv
// chess_mem_pkg
// Shared types and constants for the move-list SDRAM writer.
//   move_t      : packed 16-bit encoded move (flags, promo, to, from)
//   HDR_OFFSET  : byte offset of the count header from the list base
//   MOVE_STRIDE : byte distance between consecutive 16-bit list words
//   state_t     : writer FSM states
package chess_mem_pkg;

  typedef struct packed {
    logic [1:0] flags;
    logic [1:0] promo;
    logic [5:0] to_sq;
    logic [5:0] from_sq;
  } move_t;

  localparam int unsigned HDR_OFFSET  = 0;
  localparam int unsigned MOVE_STRIDE = 2;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    HEADER
  } state_t;

  // The header word carries the stored move count in its low byte.
  function automatic logic [15:0] header_word(input logic [7:0] count);
    return {8'h00, count};
  endfunction

endpackage

// File: rtl/move_fifo.sv
// move_fifo
// Synchronous FIFO buffering moves between the generator stream and the
// Avalon write path. Push and pop may occur in the same cycle, including
// while full (the pop frees the slot the push fills).
//   i_clk, i_reset : clock, asynchronous active-high reset (flushes FIFO)
//   i_push, i_wdata: write strobe and data
//   i_pop          : read strobe; o_rdata shows the head entry
//   o_full/o_empty : occupancy flags, combinational from o_count
//   o_count        : number of entries currently stored
module move_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int W          = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_push,
  input  logic [W-1:0]                i_wdata,
  input  logic                        i_pop,
  output logic [W-1:0]                o_rdata,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // A push while full is only legal when a pop frees the head slot.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/move_list_writer.sv
// move_list_writer
// Avalon-MM write master that collects a stream of 16-bit moves through a
// FIFO and writes them as a contiguous list into SDRAM. Move i lands at
// base + 2*(i+1); the count header is written last at base, then done pulses.
// Optional build macro MOVE_WR_CHECKSUM_EN: o_checksum is the running XOR
// of every stored move; otherwise o_checksum is tied to zero.
//   i_clk, i_reset        : clock, asynchronous active-high reset
//   i_start, i_base_addr  : begin a list at the given 2-byte aligned address
//   i_mv_valid/data/last  : move stream in, o_mv_ready back-pressure
//   o_avm_*, i_avm_waitrequest : Avalon-MM write master
//   o_busy, o_done        : activity flag, completion pulse
//   o_move_count          : moves stored in current/last list
//   o_overflow            : sticky, a move beyond MAX_MOVES was dropped
//   o_checksum            : XOR of stored moves (optional)
module move_list_writer
  import chess_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 32,
  parameter int MAX_MOVES  = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_mv_valid,
  input  logic [15:0]       i_mv_data,
  input  logic              i_mv_last,
  output logic              o_mv_ready,
  output logic [ADDR_W-1:0] o_avm_address,
  output logic              o_avm_write,
  output logic [15:0]       o_avm_writedata,
  output logic [1:0]        o_avm_byteenable,
  input  logic              i_avm_waitrequest,
  output logic              o_busy,
  output logic              o_done,
  output logic [7:0]        o_move_count,
  output logic              o_overflow,
  output logic [15:0]       o_checksum
);

  localparam int              CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]      MAX_CNT = 8'(MAX_MOVES);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(MOVE_STRIDE);
  localparam logic [ADDR_W-1:0] HDR    = ADDR_W'(HDR_OFFSET);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] r_avm_address;
  logic              r_avm_write;
  logic [15:0]       r_avm_writedata;
  logic              r_done;
  logic              r_overflow;
  logic [7:0]        r_count;
  logic              r_stg_valid;
  move_t             r_stg_data;

  logic [15:0]       w_fifo_rdata;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_start;
  logic              w_mv_ready;
  logic              w_beat;
  logic              w_push;
  logic              w_drop;
  logic              w_accept;
  logic              w_load_avm;
  logic              w_pop;

  move_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_wdata (i_mv_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_start    = (r_state == IDLE) && i_start;
  assign w_mv_ready = (r_state == FILL) && !w_fifo_full;
  assign w_beat     = i_mv_valid && w_mv_ready;
  assign w_push     = w_beat && (r_count < MAX_CNT);
  assign w_drop     = w_beat && !(r_count < MAX_CNT);
  assign w_accept   = r_avm_write && !i_avm_waitrequest;

  // A staging register sits between the FIFO head and the bus registers,
  // giving the two-edge stream-to-bus latency while still allowing a new
  // write every cycle once the pipeline is primed.
  assign w_load_avm = r_stg_valid && (!r_avm_write || w_accept);
  assign w_pop      = !w_fifo_empty && (!r_stg_valid || w_load_avm);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // DRAIN waits until every move word has left the FIFO, the staging
  // register and the bus, so the header is strictly the last write.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (i_start) w_next = FILL;
      FILL:   if (i_mv_last && (!i_mv_valid || w_mv_ready)) w_next = DRAIN;
      DRAIN:  if ((w_fifo_count == '0) && !r_stg_valid && !r_avm_write) w_next = HEADER;
      HEADER: if (w_accept) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bus registers only change when idle or on acceptance, which keeps
  // address/data/write stable across waitrequest stalls.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_base          <= '0;
      r_next_addr     <= '0;
      r_avm_address   <= '0;
      r_avm_write     <= 1'b0;
      r_avm_writedata <= '0;
      r_done          <= 1'b0;
      r_overflow      <= 1'b0;
      r_count         <= '0;
      r_stg_valid     <= 1'b0;
      r_stg_data      <= '0;
    end else begin
      r_done <= (r_state == HEADER) && w_accept;
      if (w_start) begin
        r_base      <= i_base_addr;
        r_next_addr <= i_base_addr + STRIDE;
        r_count     <= '0;
        r_overflow  <= 1'b0;
      end
      if (w_push) r_count    <= r_count + 8'd1;
      if (w_drop) r_overflow <= 1'b1;
      if (w_pop) begin
        r_stg_valid <= 1'b1;
        r_stg_data  <= move_t'(w_fifo_rdata);
      end else if (w_load_avm) begin
        r_stg_valid <= 1'b0;
      end
      if ((r_state == DRAIN) && (w_next == HEADER)) begin
        r_avm_write     <= 1'b1;
        r_avm_address   <= r_base + HDR;
        r_avm_writedata <= header_word(r_count);
      end else if (w_load_avm) begin
        r_avm_write     <= 1'b1;
        r_avm_address   <= r_next_addr;
        r_avm_writedata <= r_stg_data;
        r_next_addr     <= r_next_addr + STRIDE;
      end else if (w_accept) begin
        r_avm_write <= 1'b0;
      end
    end
  end

`ifdef MOVE_WR_CHECKSUM_EN
  logic [15:0] r_checksum;

  // Only moves actually stored contribute; dropped overflow moves do not.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)     r_checksum <= '0;
    else if (w_start) r_checksum <= '0;
    else if (w_push)  r_checksum <= r_checksum ^ i_mv_data;
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = 16'h0000;
`endif

  assign o_mv_ready       = w_mv_ready;
  assign o_avm_address    = r_avm_address;
  assign o_avm_write      = r_avm_write;
  assign o_avm_writedata  = r_avm_writedata;
  assign o_avm_byteenable = 2'b11;
  assign o_busy           = (r_state != IDLE);
  assign o_done           = r_done;
  assign o_move_count     = r_count;
  assign o_overflow       = r_overflow;

endmodule

// File: tb/tb_move_list_writer.sv
// tb_move_list_writer
// Self-checking bench for move_list_writer: directed vector table,
// hand-written latency/stall/reset sequences and randomized lists compared
// against a list-level reference model (expected writes, count, overflow,
// checksum) built directly from the move list.
module tb_move_list_writer;

  localparam int FIFO_DEPTH = 16;
  localparam int ADDR_W     = 32;
  localparam int MAXM       = 255;
  localparam int TMO        = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] baseAddr = '0;
  logic        mvValid = 1'b0;
  logic [15:0] mvData = '0;
  logic        mvLast = 1'b0;
  logic        mvReady;
  logic [31:0] avmAddress;
  logic        avmWrite;
  logic [15:0] avmWritedata;
  logic [1:0]  avmByteenable;
  logic        avmWaitrequest;
  logic        busy;
  logic        done;
  logic [7:0]  moveCount;
  logic        overflow;
  logic [15:0] checksum;

  int checks = 0;
  int errors = 0;

  logic        randWait = 1'b0;
  bit          randEn = 1'b0;
  logic [31:0] stallAddr = 32'hFFFF_FFFF;
  int          stallCount = 0;
  int          stallLimit = 0;
  logic        stallNow;

  logic [47:0] wrQ[$];
  int          doneCount = 0;
  int          outstandingAtFull = -1;
  logic        prevPending = 1'b0;
  logic [31:0] prevAddr = '0;
  logic [15:0] prevData = '0;

  typedef struct {
    logic [31:0]       base;
    int                n;
    logic [2:0][15:0]  mv;
    bit                rw;
    logic [7:0]        expCount;
    logic [15:0]       expHdr;
    logic [15:0]       expCsum;
  } vec_t;

  vec_t        vecs[4];
  logic [15:0] mvQ[$];
  int          acc;
  logic [31:0] b;
  int          s0;

  move_list_writer #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .MAX_MOVES(MAXM)) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_start           (start),
    .i_base_addr       (baseAddr),
    .i_mv_valid        (mvValid),
    .i_mv_data         (mvData),
    .i_mv_last         (mvLast),
    .o_mv_ready        (mvReady),
    .o_avm_address     (avmAddress),
    .o_avm_write       (avmWrite),
    .o_avm_writedata   (avmWritedata),
    .o_avm_byteenable  (avmByteenable),
    .i_avm_waitrequest (avmWaitrequest),
    .o_busy            (busy),
    .o_done            (done),
    .o_move_count      (moveCount),
    .o_overflow        (overflow),
    .o_checksum        (checksum)
  );

  always #5 clk = ~clk;

  // Slave model: random stalls plus a scripted stall on one address.
  assign stallNow       = avmWrite && (avmAddress == stallAddr) && (stallCount < stallLimit);
  assign avmWaitrequest = randWait | stallNow;

  always @(posedge clk) begin
    randWait <= randEn ? ($urandom_range(0, 3) == 0) : 1'b0;
    if (stallNow) stallCount <= stallCount + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor: records accepted writes, done pulses, and checks that a
  // stalled request holds address/data/write until accepted.
  always @(negedge clk) begin
    if (!rst) begin
      if (prevPending) begin
        checkOutput("stall hold write", 64'(avmWrite), 64'(1));
        checkOutput("stall hold addr", 64'(avmAddress), 64'(prevAddr));
        checkOutput("stall hold data", 64'(avmWritedata), 64'(prevData));
      end
      prevPending = avmWrite && avmWaitrequest;
      prevAddr    = avmAddress;
      prevData    = avmWritedata;
      if (avmWrite && !avmWaitrequest) wrQ.push_back({avmAddress, avmWritedata});
      if (done) doneCount++;
    end else begin
      prevPending = 1'b0;
    end
  end

  task automatic startList(input logic [31:0] base);
    @(negedge clk);
    wrQ.delete();
    doneCount = 0;
    @(posedge clk); #1;
    start    = 1'b1;
    baseAddr = base;
    @(posedge clk); #1;
    start    = 1'b0;
    baseAddr = $urandom;
  endtask

  // Streams the moves; with gaps set it inserts idle cycles and stray
  // start pulses (which must be ignored while busy).
  task automatic applyStimulus(input logic [15:0] mv[$], input bit gaps, output int accepted);
    int  t;
    bit  got;
    accepted = 0;
    if (mv.size() == 0) begin
      mvValid = 1'b0;
      mvLast  = 1'b1;
      @(posedge clk); #1;
      mvLast  = 1'b0;
      return;
    end
    for (int i = 0; i < mv.size(); i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        mvValid = 1'b0;
        mvLast  = 1'b0;
        mvData  = 16'($urandom);
        @(posedge clk); #1;
      end
      mvValid = 1'b1;
      mvData  = mv[i];
      mvLast  = (i == mv.size() - 1);
      if (gaps) begin
        start    = ($urandom_range(0, 5) == 0);
        baseAddr = $urandom;
      end
      got = 1'b0;
      t   = 0;
      while (!got && t < TMO) begin
        @(negedge clk);
        if (mvReady) got = 1'b1;
        else if (outstandingAtFull < 0) outstandingAtFull = accepted - wrQ.size();
        @(posedge clk); #1;
        t++;
      end
      start = 1'b0;
      if (!got) begin
        checkOutput("beat accept timeout", 64'(0), 64'(1));
        break;
      end
      accepted++;
    end
    mvValid = 1'b0;
    mvLast  = 1'b0;
  endtask

  task automatic waitDone();
    int t = 0;
    while (busy && t < TMO * 4) begin
      @(negedge clk);
      t++;
    end
    checkOutput("list completion timeout (busy)", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  // Reference model: list-level expectations from the move list alone.
  task automatic checkList(input string tag, input logic [31:0] base, input logic [15:0] mv[$]);
    logic [47:0] expQ[$];
    logic [15:0] x = '0;
    int          n = (mv.size() > MAXM) ? MAXM : mv.size();
    for (int i = 0; i < n; i++) begin
      expQ.push_back({base + 32'(2 * (i + 1)), mv[i]});
      x ^= mv[i];
    end
    expQ.push_back({base, 16'(n)});
    checkOutput($sformatf("%s write count", tag), 64'(wrQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < wrQ.size(); i++)
      checkOutput($sformatf("%s write %0d addr_data", tag, i), 64'(wrQ[i]), 64'(expQ[i]));
    checkOutput($sformatf("%s move_count", tag), 64'(moveCount), 64'(n));
    checkOutput($sformatf("%s overflow", tag), 64'(overflow), 64'(mv.size() > MAXM));
`ifdef MOVE_WR_CHECKSUM_EN
    checkOutput($sformatf("%s checksum", tag), 64'(checksum), 64'(x));
`else
    checkOutput($sformatf("%s checksum", tag), 64'(checksum), 64'(0));
`endif
    checkOutput($sformatf("%s done pulses", tag), 64'(doneCount), 64'(1));
    checkOutput($sformatf("%s busy after done", tag), 64'(busy), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{base: 32'h0000_1000, n: 3, mv: {16'hC0FF, 16'h1234, 16'h0A1C}, rw: 1'b0,
                expCount: 8'd3, expHdr: 16'h0003, expCsum: 16'hD8D7};
    vecs[1] = '{base: 32'h0000_0000, n: 0, mv: '0, rw: 1'b0,
                expCount: 8'd0, expHdr: 16'h0000, expCsum: 16'h0000};
    vecs[2] = '{base: 32'h0000_2FFE, n: 1, mv: {16'h0, 16'h0, 16'hFFFF}, rw: 1'b1,
                expCount: 8'd1, expHdr: 16'h0001, expCsum: 16'hFFFF};
    vecs[3] = '{base: 32'h8000_0010, n: 2, mv: {16'h0, 16'h00FF, 16'h0F0F}, rw: 1'b0,
                expCount: 8'd2, expHdr: 16'h0002, expCsum: 16'h0FF0};

    // Reset state.
    @(negedge clk);
    checkOutput("reset mv_ready", 64'(mvReady), 64'(0));
    checkOutput("reset avm_write", 64'(avmWrite), 64'(0));
    checkOutput("reset avm_address", 64'(avmAddress), 64'(0));
    checkOutput("reset avm_writedata", 64'(avmWritedata), 64'(0));
    checkOutput("reset byteenable", 64'(avmByteenable), 64'(2'b11));
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset done", 64'(done), 64'(0));
    checkOutput("reset move_count", 64'(moveCount), 64'(0));
    checkOutput("reset overflow", 64'(overflow), 64'(0));
    checkOutput("reset checksum", 64'(checksum), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed vector table.
    for (int v = 0; v < 4; v++) begin
      randEn = vecs[v].rw;
      mvQ.delete();
      for (int j = 0; j < vecs[v].n; j++) mvQ.push_back(vecs[v].mv[j]);
      startList(vecs[v].base);
      checkOutput($sformatf("vec%0d busy in FILL", v), 64'(busy), 64'(1));
      applyStimulus(mvQ, 1'b0, acc);
      waitDone();
      checkList($sformatf("vec%0d", v), vecs[v].base, mvQ);
      checkOutput($sformatf("vec%0d table count", v), 64'(moveCount), 64'(vecs[v].expCount));
      if (wrQ.size() == 0) checkOutput($sformatf("vec%0d header present", v), 64'(0), 64'(1));
      else checkOutput($sformatf("vec%0d table header", v), 64'(wrQ[wrQ.size()-1]), 64'({vecs[v].base, vecs[v].expHdr}));
`ifdef MOVE_WR_CHECKSUM_EN
      checkOutput($sformatf("vec%0d table checksum", v), 64'(checksum), 64'(vecs[v].expCsum));
`endif
    end
    randEn = 1'b0;

    // Latency with an idle bus: beat on edge k appears on the bus after k+2.
    startList(32'h0000_0100);
    mvValid = 1'b1;
    mvData  = 16'hBEEF;
    mvLast  = 1'b1;
    @(negedge clk);
    checkOutput("lat ready", 64'(mvReady), 64'(1));
    @(posedge clk); #1;
    mvValid = 1'b0;
    mvLast  = 1'b0;
    @(negedge clk);
    checkOutput("lat write after k", 64'(avmWrite), 64'(0));
    @(negedge clk);
    checkOutput("lat write after k+1", 64'(avmWrite), 64'(0));
    @(negedge clk);
    checkOutput("lat write after k+2", 64'(avmWrite), 64'(1));
    checkOutput("lat data after k+2", 64'(avmWritedata), 64'(16'hBEEF));
    checkOutput("lat addr after k+2", 64'(avmAddress), 64'(32'h0000_0102));
    waitDone();
    mvQ.delete();
    mvQ.push_back(16'hBEEF);
    checkList("latency", 32'h0000_0100, mvQ);

    // Short stall on the second move write.
    b = 32'h0000_4000;
    mvQ.delete();
    for (int i = 0; i < 6; i++) mvQ.push_back(16'($urandom));
    stallAddr  = b + 32'd4;
    s0         = stallCount;
    stallLimit = stallCount + 5;
    startList(b);
    applyStimulus(mvQ, 1'b0, acc);
    waitDone();
    checkList("stall5", b, mvQ);
    checkOutput("stall5 stall cycles", 64'(stallCount - s0), 64'(5));

    // Long stall: the stream must back-pressure once the FIFO is full.
    b = 32'h0000_5000;
    mvQ.delete();
    for (int i = 0; i < 30; i++) mvQ.push_back(16'($urandom));
    stallAddr         = b + 32'd4;
    s0                = stallCount;
    stallLimit        = stallCount + 40;
    outstandingAtFull = -1;
    startList(b);
    applyStimulus(mvQ, 1'b0, acc);
    waitDone();
    checkList("stall40", b, mvQ);
    checkOutput("stall40 stall cycles", 64'(stallCount - s0), 64'(40));
    checkOutput($sformatf("stall40 moves queued at ready drop=%0d in [%0d..%0d]",
                          outstandingAtFull, FIFO_DEPTH, FIFO_DEPTH + 2),
                64'((outstandingAtFull >= FIFO_DEPTH) && (outstandingAtFull <= FIFO_DEPTH + 2)), 64'(1));
    checkOutput("stall40 beats accepted", 64'(acc), 64'(30));

    // Overflow: 257 moves, the last two dropped but still accepted.
    b = 32'h0001_0000;
    mvQ.delete();
    for (int i = 0; i < 257; i++) mvQ.push_back(16'($urandom));
    startList(b);
    applyStimulus(mvQ, 1'b0, acc);
    waitDone();
    checkList("ovf", b, mvQ);
    checkOutput("ovf beats accepted", 64'(acc), 64'(257));

    // Reset while draining with a write stalled on the bus.
    b = 32'h0000_6000;
    mvQ.delete();
    mvQ.push_back(16'h1111);
    mvQ.push_back(16'h2222);
    mvQ.push_back(16'h3333);
    stallAddr  = b + 32'd2;
    stallLimit = stallCount + 100000;
    startList(b);
    applyStimulus(mvQ, 1'b0, acc);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst pre busy", 64'(busy), 64'(1));
    checkOutput("rst pre write outstanding", 64'(avmWrite), 64'(1));
    rst = 1'b1;
    #1;
    checkOutput("rst async avm_write", 64'(avmWrite), 64'(0));
    checkOutput("rst async busy", 64'(busy), 64'(0));
    checkOutput("rst async move_count", 64'(moveCount), 64'(0));
    @(posedge clk); #1;
    rst        = 1'b0;
    stallLimit = stallCount;
    repeat (5) @(negedge clk);
    checkOutput("rst no done", 64'(doneCount), 64'(0));
    checkOutput("rst no writes", 64'(wrQ.size()), 64'(0));
    checkOutput("rst idle busy", 64'(busy), 64'(0));
    b = 32'h0000_6100;
    mvQ.delete();
    for (int i = 0; i < 4; i++) mvQ.push_back(16'($urandom));
    startList(b);
    applyStimulus(mvQ, 1'b0, acc);
    waitDone();
    checkList("after reset", b, mvQ);

    // Randomized lists with bus stalls, stream gaps and stray starts.
    for (int it = 0; it < 6; it++) begin
      b = $urandom & 32'hFFFF_FFFE;
      mvQ.delete();
      for (int i = 0; i < $urandom_range(1, 40); i++) mvQ.push_back(16'($urandom));
      randEn = 1'b1;
      startList(b);
      applyStimulus(mvQ, 1'b1, acc);
      waitDone();
      checkList($sformatf("rand%0d", it), b, mvQ);
      checkOutput($sformatf("rand%0d beats accepted", it), 64'(acc), 64'(mvQ.size()));
    end
    randEn = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
